// File: rtl/refill_source.sv
// Refill channel producer: queues line misses, reads backing memory,
// and returns lines in miss order on the memctl refill handshake.
module refill_source #(
  parameter int NlineWidth     = 16,
  parameter int DataWidth      = 128,
  parameter int MissDepth      = 8,
  parameter int MaxOutstanding = 4,
  parameter int RspDepth       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  u_miss_valid,
  output logic                  u_miss_ready,
  input  logic [NlineWidth-1:0] u_miss_id,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [NlineWidth-1:0] mem_req_id,
  input  logic                  mem_rsp_valid,
  input  logic [DataWidth-1:0]  mem_rsp_data,
  output logic                  memctl_refill_valid,
  input  logic                  memctl_refill_ready,
  output logic [NlineWidth-1:0] memctl_refill_id,
  output logic [DataWidth-1:0]  memctl_refill_data,
  output logic                  idle,
  output logic                  proto_err
);

  localparam int MAW = (MissDepth > 1) ? $clog2(MissDepth) : 1;
  localparam int MCW = $clog2(MissDepth + 1);
  localparam int TAW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int TCW = $clog2(MaxOutstanding + 1);
  localparam int RAW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int RCW = $clog2(RspDepth + 1);

  logic [NlineWidth-1:0] miss_mem_q [MissDepth];
  logic [NlineWidth-1:0] tag_mem_q  [MaxOutstanding];
  logic [NlineWidth-1:0] rid_mem_q  [RspDepth];
  logic [DataWidth-1:0]  rdat_mem_q [RspDepth];

  logic [MAW-1:0] mwp_q, mwp_d, mrp_q, mrp_d;
  logic [MCW-1:0] mcnt_q, mcnt_d;
  logic [TAW-1:0] twp_q, twp_d, trp_q, trp_d;
  logic [TCW-1:0] out_q, out_d;
  logic [RAW-1:0] rwp_q, rwp_d, rrp_q, rrp_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic           perr_q, perr_d;

  logic miss_empty, miss_full;
  logic miss_push, req_fire, rsp_fire, rfl_fire;

  always_comb begin
    miss_empty = (mcnt_q == '0);
    miss_full  = (mcnt_q == MCW'(MissDepth));
    u_miss_ready = !miss_full;
    // Credit gate: every in-flight read already owns a response slot
    mem_req_valid = !miss_empty
                 && (32'(out_q) < 32'(MaxOutstanding))
                 && (32'(out_q) + 32'(rcnt_q) < 32'(RspDepth));
    mem_req_id = miss_empty ? '0 : miss_mem_q[mrp_q];
    memctl_refill_valid = (rcnt_q != '0);
    memctl_refill_id   = memctl_refill_valid ? rid_mem_q[rrp_q]  : '0;
    memctl_refill_data = memctl_refill_valid ? rdat_mem_q[rrp_q] : '0;
    idle = miss_empty && (out_q == '0) && (rcnt_q == '0);
    proto_err = perr_q;

    miss_push = u_miss_valid && u_miss_ready;
    req_fire  = mem_req_valid && mem_req_ready;
    rsp_fire  = mem_rsp_valid && (out_q != '0);
    rfl_fire  = memctl_refill_valid && memctl_refill_ready;

    mwp_d  = mwp_q;
    mrp_d  = mrp_q;
    mcnt_d = mcnt_q;
    twp_d  = twp_q;
    trp_d  = trp_q;
    out_d  = out_q;
    rwp_d  = rwp_q;
    rrp_d  = rrp_q;
    rcnt_d = rcnt_q;
    perr_d = perr_q || (mem_rsp_valid && (out_q == '0));

    if (miss_push)
      mwp_d = (mwp_q == MAW'(MissDepth - 1)) ? '0 : mwp_q + MAW'(1);
    if (req_fire) begin
      mrp_d = (mrp_q == MAW'(MissDepth - 1)) ? '0 : mrp_q + MAW'(1);
      twp_d = (twp_q == TAW'(MaxOutstanding - 1)) ? '0 : twp_q + TAW'(1);
    end
    if (miss_push && !req_fire) mcnt_d = mcnt_q + MCW'(1);
    if (!miss_push && req_fire) mcnt_d = mcnt_q - MCW'(1);

    if (rsp_fire) begin
      trp_d = (trp_q == TAW'(MaxOutstanding - 1)) ? '0 : trp_q + TAW'(1);
      rwp_d = (rwp_q == RAW'(RspDepth - 1)) ? '0 : rwp_q + RAW'(1);
    end
    if (req_fire && !rsp_fire) out_d = out_q + TCW'(1);
    if (!req_fire && rsp_fire) out_d = out_q - TCW'(1);

    if (rfl_fire)
      rrp_d = (rrp_q == RAW'(RspDepth - 1)) ? '0 : rrp_q + RAW'(1);
    if (rsp_fire && !rfl_fire) rcnt_d = rcnt_q + RCW'(1);
    if (!rsp_fire && rfl_fire) rcnt_d = rcnt_q - RCW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mwp_q  <= '0;
      mrp_q  <= '0;
      mcnt_q <= '0;
      twp_q  <= '0;
      trp_q  <= '0;
      out_q  <= '0;
      rwp_q  <= '0;
      rrp_q  <= '0;
      rcnt_q <= '0;
      perr_q <= 1'b0;
    end else begin
      mwp_q  <= mwp_d;
      mrp_q  <= mrp_d;
      mcnt_q <= mcnt_d;
      twp_q  <= twp_d;
      trp_q  <= trp_d;
      out_q  <= out_d;
      rwp_q  <= rwp_d;
      rrp_q  <= rrp_d;
      rcnt_q <= rcnt_d;
      perr_q <= perr_d;
    end
  end

  // Payload storage needs no reset; outputs are masked by the counts
  always_ff @(posedge clk) begin
    if (miss_push) miss_mem_q[mwp_q] <= u_miss_id;
    if (req_fire)  tag_mem_q[twp_q]  <= miss_mem_q[mrp_q];
    if (rsp_fire) begin
      rid_mem_q[rwp_q]  <= tag_mem_q[trp_q];
      rdat_mem_q[rwp_q] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_refill_source.sv
// Randomized bench for refill_source against a queue-based
// model of miss order, in-flight reads and buffered refills.
module tb_refill_source;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         u_miss_valid;
  logic         u_miss_ready;
  logic [15:0]  u_miss_id;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [15:0]  mem_req_id;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic         memctl_refill_valid;
  logic         memctl_refill_ready;
  logic [15:0]  memctl_refill_id;
  logic [127:0] memctl_refill_data;
  logic         idle;
  logic         proto_err;

  refill_source dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .u_miss_valid        (u_miss_valid),
    .u_miss_ready        (u_miss_ready),
    .u_miss_id           (u_miss_id),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_id          (mem_req_id),
    .mem_rsp_valid       (mem_rsp_valid),
    .mem_rsp_data        (mem_rsp_data),
    .memctl_refill_valid (memctl_refill_valid),
    .memctl_refill_ready (memctl_refill_ready),
    .memctl_refill_id    (memctl_refill_id),
    .memctl_refill_data  (memctl_refill_data),
    .idle                (idle),
    .proto_err           (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] id;
    int          due;
  } pend_t;

  logic [15:0]  miss_q[$];
  pend_t        pend_q[$];
  logic [143:0] exp_q[$];
  int           cyc;
  int           total;
  int           bad;
  logic         exp_perr;

  task automatic chk(input string tag,
                     input logic [143:0] got,
                     input logic [143:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_miss_ready", 144'(u_miss_ready), 144'(1));
    chk("rst_req_valid", 144'(mem_req_valid), 144'(0));
    chk("rst_req_id", 144'(mem_req_id), 144'(0));
    chk("rst_rfl_valid", 144'(memctl_refill_valid), 144'(0));
    chk("rst_rfl_beat", {memctl_refill_id, memctl_refill_data}, 144'(0));
    chk("rst_idle", 144'(idle), 144'(1));
    chk("rst_perr", 144'(proto_err), 144'(0));
  endtask

  task automatic clear_model();
    miss_q.delete();
    pend_q.delete();
    exp_q.delete();
    exp_perr = 1'b0;
  endtask

  task automatic step(input bit gen_miss, input int p_req,
                      input int p_rfl);
    int          nout;
    int          nbuf;
    bit          rsp;
    bit          exp_v;
    pend_t       p;
    logic [15:0] hid;
    @(negedge clk);
    u_miss_valid = gen_miss && ($urandom_range(0, 99) < 60);
    u_miss_id    = 16'($urandom);
    mem_req_ready = ($urandom_range(0, 99) < p_req);
    memctl_refill_ready = ($urandom_range(0, 99) < p_rfl);
    rsp = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    mem_rsp_valid = rsp;
    mem_rsp_data = rsp ? {$urandom, $urandom, $urandom, $urandom} : '0;
    #1;
    nout = pend_q.size();
    nbuf = exp_q.size();
    chk("miss_ready", 144'(u_miss_ready), 144'(miss_q.size() < 8));
    exp_v = (miss_q.size() > 0) && (nout < 4) && (nout + nbuf < 4);
    chk("req_valid", 144'(mem_req_valid), 144'(exp_v));
    if (mem_req_valid && miss_q.size() > 0)
      chk("req_id", 144'(mem_req_id), 144'(miss_q[0]));
    chk("rfl_valid", 144'(memctl_refill_valid), 144'(nbuf > 0));
    if (memctl_refill_valid && nbuf > 0)
      chk("rfl_beat", {memctl_refill_id, memctl_refill_data}, exp_q[0]);
    chk("idle", 144'(idle),
        144'(miss_q.size() == 0 && nout == 0 && nbuf == 0));
    chk("perr", 144'(proto_err), 144'(exp_perr));
    if (memctl_refill_valid && memctl_refill_ready && nbuf > 0)
      void'(exp_q.pop_front());
    if (rsp) begin
      p = pend_q.pop_front();
      exp_q.push_back({p.id, mem_rsp_data});
    end
    if (mem_req_valid && mem_req_ready && miss_q.size() > 0) begin
      hid = miss_q.pop_front();
      p.id  = hid;
      p.due = cyc + 1 + int'($urandom_range(0, 4));
      pend_q.push_back(p);
    end
    if (u_miss_valid && u_miss_ready) miss_q.push_back(u_miss_id);
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((miss_q.size() + pend_q.size() + exp_q.size() > 0) && n < 300) begin
      step(1'b0, 100, 100);
      n++;
    end
    chk("drained", 144'(miss_q.size() + pend_q.size() + exp_q.size()),
        144'(0));
    step(1'b0, 100, 100);
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    clear_model();
    rst_n = 1'b0;
    u_miss_valid = 1'b0;
    u_miss_id = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    memctl_refill_ready = 1'b0;
    #1;
    chk_reset_outs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Traffic mixes: free flow, memory stall, consumer stall, sparse
    for (int ph = 0; ph < 12; ph++) begin
      int pr;
      int pf;
      case (ph % 4)
        0: begin pr = 90; pf = 90; end
        1: begin pr = 10; pf = 80; end
        2: begin pr = 80; pf = 5;  end
        default: begin pr = 50; pf = 50; end
      endcase
      for (int i = 0; i < 150; i++) step(1'b1, pr, pf);
    end
    drain();

    // Response with nothing outstanding must set sticky proto_err
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = {4{32'hdead_beef}};
    memctl_refill_ready = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    #1;
    chk("perr_set", 144'(proto_err), 144'(1));
    chk("perr_no_rfl", 144'(memctl_refill_valid), 144'(0));
    exp_perr = 1'b1;
    for (int i = 0; i < 40; i++) step(1'b1, 70, 70);

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 30; i++) step(1'b1, 60, 10);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    u_miss_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    chk_reset_outs();
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) step(1'b1, 70, 70);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
